tile_writer: RTL and testbench

Upstream feeder for the tile-map color mapper. Accepts tile-update requests from game logic over a valid/ready handshake, queues them, and serialises them onto the 32-bit `control` word, one tile write per cycle. Also runs a full-screen clear sweep that writes one tile code to every cell of the 40x30 map.

---
 rtl/tile_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/tile_writer.sv | 136 +++++++++++++
 tb/tb_tile_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared tile-map definitions: map geometry, control word layout, request payload and writer states.
package tile_pkg;

  localparam int unsigned ROWS = 30;
  localparam int unsigned COLS = 40;

  localparam int unsigned CTRL_W   = 32;
  localparam int unsigned TILE_LSB = 0;
  localparam int unsigned TILE_W   = 8;
  localparam int unsigned ROW_LSB  = 8;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned COL_LSB  = 14;
  localparam int unsigned COL_W    = 6;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [TILE_W-1:0] tile;
  } tile_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } writer_state_t;

  // Build a map write word; unused upper bits stay zero.
  function automatic logic [CTRL_W-1:0] pack_control(input logic [COL_W-1:0]  col,
                                                     input logic [ROW_W-1:0]  row,
                                                     input logic [TILE_W-1:0] tile);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[TILE_LSB +: TILE_W] = tile;
    w[ROW_LSB  +: ROW_W]  = row;
    w[COL_LSB  +: COL_W]  = col;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; flush discards stored entries but keeps a same-cycle push.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    do_push = push && !full_q;
    do_pop  = pop && !empty_q && !flush;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end
    if (do_push) begin
      wr_d  = wr_q + PTR_W'(1);
      cnt_d = cnt_d + CNT_W'(1);
    end
    if (do_pop) begin
      rd_d  = rd_q + PTR_W'(1);
      cnt_d = cnt_d - CNT_W'(1);
    end
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata_c = mem_q[rd_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = cnt_q;

endmodule

// File: rtl/tile_writer.sv
// Queues tile-update requests and serialises them onto the map control word; also sweeps a full-screen clear.
module tile_writer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ROWS  = tile_pkg::ROWS,
  parameter int unsigned COLS  = tile_pkg::COLS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_row,
  input  logic [5:0]  req_col,
  input  logic [7:0]  req_tile,
  input  logic        clear_start,
  input  logic [7:0]  clear_tile,
  output logic        busy,
  output logic [7:0]  dropped,
  output logic [31:0] control
);

  import tile_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned REQ_W = $bits(tile_req_t);
  localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  writer_state_t      state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [TILE_W-1:0]  ctile_q, ctile_d;
  logic [CTRL_W-1:0]  control_q, control_d;
  logic [7:0]         dropped_q, dropped_d;
  logic               busy_q, busy_d;
  logic               avail_q, avail_d;

  tile_req_t          wr_req, rd_req;
  logic [REQ_W-1:0]   rd_raw;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               accept, in_range, push, start, pop;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (start),
    .wdata   (wr_req),
    .rdata_c (rd_raw),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // avail_q lags FIFO occupancy one cycle, giving the two-edge request-to-control latency.
  always_comb begin
    wr_req    = '{row: req_row, col: req_col, tile: req_tile};
    rd_req    = tile_req_t'(rd_raw);
    accept    = req_valid && !fifo_full;
    in_range  = (req_row < ROW_LIM) && (req_col < COL_LIM);
    push      = accept && in_range;
    start     = (state_q == IDLE) && clear_start;
    pop       = (state_q == IDLE) && !clear_start && avail_q && !fifo_empty;

    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    ctile_d   = ctile_q;
    control_d = control_q;
    dropped_d = dropped_q;
    avail_d   = !fifo_empty;

    if (accept && !in_range && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          row_d   = '0;
          col_d   = '0;
          ctile_d = clear_tile;
        end else if (pop) begin
          control_d = pack_control(rd_req.col, rd_req.row, rd_req.tile);
        end
      end
      CLEAR: begin
        control_d = pack_control(col_q, row_q, ctile_q);
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) state_d = IDLE;
          else                   row_d   = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CLEAR) || push || (fifo_count > CNT_W'(1)) ||
             ((fifo_count == CNT_W'(1)) && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      ctile_q   <= '0;
      control_q <= '0;
      dropped_q <= '0;
      busy_q    <= 1'b0;
      avail_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ctile_q   <= ctile_d;
      control_q <= control_d;
      dropped_q <= dropped_d;
      busy_q    <= busy_d;
      avail_q   <= avail_d;
    end
  end

  assign req_ready = !fifo_full;
  assign busy      = busy_q;
  assign dropped   = dropped_q;
  assign control   = control_q;

endmodule

// File: tb/tb_tile_writer.sv
// Self-checking bench for tile_writer: directed and random requests against a queue-based write-order model.
module tb_tile_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_row, req_col;
  logic [7:0]  req_tile;
  logic        clear_start;
  logic [7:0]  clear_tile;
  logic        busy;
  logic [7:0]  dropped;
  logic [31:0] control;

  always #5 clk = ~clk;

  tile_writer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_row     (req_row),
    .req_col     (req_col),
    .req_tile    (req_tile),
    .clear_start (clear_start),
    .clear_tile  (clear_tile),
    .busy        (busy),
    .dropped     (dropped),
    .control     (control)
  );

  int          total = 0;
  int          bad   = 0;
  int          cycle = 0;
  int          drops = 0;
  logic [31:0] exp_q [$];
  logic [31:0] prev_ctrl = '0;
  bit          mon_en = 1'b1;

  function automatic logic [31:0] word(input int r, input int c, input int t);
    return 32'(c * 16384 + r * 256 + t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; every change of control must be the next write the model predicts.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    if (mon_en && (control !== prev_ctrl)) begin
      if (exp_q.size() == 0) chk("spurious_write", control, prev_ctrl);
      else                   chk("write_order", control, exp_q.pop_front());
    end
    prev_ctrl = control;
  endtask

  task automatic model_accept(input int r, input int c, input int t);
    if (r < 30 && c < 40) exp_q.push_back(word(r, c, t));
    else if (drops < 255) drops++;
  endtask

  task automatic send(input int r, input int c, input int t);
    logic rdy;
    int   n;
    req_valid = 1'b1;
    req_row   = 6'(r);
    req_col   = 6'(c);
    req_tile  = 8'(t);
    n = 0;
    do begin
      rdy = req_ready;
      step();
      n++;
    end while (!rdy && n < 3000);
    if (!rdy) chk("send_timeout", {31'b0, rdy}, 32'd1);
    else      model_accept(r, c, t);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_sweep(input int t);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        exp_q.push_back(word(r, c, t));
  endtask

  initial begin
    int   ecyc, occ, i, n;
    logic rdy;

    reset = 1'b1; req_valid = 1'b0; clear_start = 1'b0; clear_tile = '0;
    req_row = '0; req_col = '0; req_tile = '0;
    mon_en = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    mon_en = 1'b1;
    chk("rst_control", control, 32'h0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);

    // Single request: two-edge latency, busy for two cycles.
    send(5, 12, 8'h2A);
    req_valid = 1'b0;
    chk("single_busy_n0", {31'b0, busy}, 32'd1);
    step();
    chk("single_lat1", control, 32'h0);
    chk("single_busy_n1", {31'b0, busy}, 32'd1);
    step();
    chk("single_lat2", control, 32'h0003_052A);
    chk("single_busy_n2", {31'b0, busy}, 32'd0);

    // Out-of-range rows/cols are consumed and counted, never written.
    send(30, 0, 8'h11);
    send(0, 40, 8'h12);
    req_valid = 1'b0;
    repeat (3) step();
    chk("dropped_two", 32'(dropped), 32'd2);

    // Random mix of in-range and out-of-range requests with random gaps.
    for (int k = 0; k < 40; k++) begin
      send(int'($urandom_range(0, 33)), int'($urandom_range(0, 43)), 8'h40 + k);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
    end
    drain();
    chk("dropped_random", 32'(dropped), 32'(drops));

    // Clear sweep with queued entries and a same-cycle request that must survive the flush.
    send(1, 1, 8'hA1);
    send(2, 2, 8'hA2);
    send(3, 3, 8'hA3);
    req_row = 6'd4; req_col = 6'd4; req_tile = 8'hF0;
    clear_start = 1'b1; clear_tile = 8'h07;
    exp_q.delete();
    load_sweep(8'h07);
    rdy = req_ready;
    step();
    ecyc = cycle;
    clear_start = 1'b0;
    chk("clear_same_ready", {31'b0, rdy}, 32'd1);
    model_accept(4, 4, 8'hF0);
    chk("clear_busy", {31'b0, busy}, 32'd1);
    occ = 1;

    // 20-request burst during the sweep fills the FIFO; clear re-pulsed mid-sweep is ignored.
    i = 0;
    n = 0;
    clear_tile = 8'h55;
    while (i < 20 && n < 1500) begin
      req_valid = 1'b1;
      req_row   = 6'(i % 30);
      req_col   = 6'((i * 3) % 40);
      req_tile  = 8'(8'h80 + i);
      clear_start = (cycle - ecyc == 599);
      if (cycle - ecyc <= 1200) chk("sweep_ready", {31'b0, req_ready}, (occ < 16) ? 32'd1 : 32'd0);
      rdy = req_ready;
      step();
      n++;
      clear_start = 1'b0;
      if (rdy) begin
        model_accept(i % 30, (i * 3) % 40, 8'h80 + i);
        occ++;
        i++;
      end
      if (cycle - ecyc == 1200) chk("sweep_last", control, word(29, 39, 8'h07));
      if (cycle - ecyc == 1201) chk("first_after_sweep", control, word(4, 4, 8'hF0));
    end
    if (i < 20) chk("burst_timeout", 32'(i), 32'd20);
    drain();
    chk("idle_after_drain", {31'b0, busy}, 32'd0);

    // Dropped counter saturates.
    for (int k = 0; k < 300; k++) send(30 + (k % 2), 0, k);
    req_valid = 1'b0;
    step();
    chk("dropped_sat", 32'(dropped), 32'(drops));
    chk("dropped_sat_255", 32'(dropped), 32'd255);

    // Reset mid-sweep abandons the sweep and the queued requests.
    clear_start = 1'b1; clear_tile = 8'h33;
    load_sweep(8'h33);
    step();
    ecyc = cycle;
    clear_start = 1'b0;
    send(6, 7, 8'hB1);
    send(8, 9, 8'hB2);
    req_valid = 1'b0;
    while (cycle - ecyc < 399) step();
    reset = 1'b1;
    mon_en = 1'b0;
    step();
    reset = 1'b0;
    chk("mid_rst_control", control, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_dropped", 32'(dropped), 32'd0);
    exp_q.delete();
    drops = 0;
    mon_en = 1'b1;
    repeat (4) step();
    chk("post_rst_idle", control, 32'h0);
    send(2, 3, 8'hC4);
    drain();
    chk("post_rst_write", control, word(2, 3, 8'hC4));
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
